// File: rtl/input_debouncer_if.sv
`default_nettype none
// ============================================================================
// Module  : input_debouncer_if
// Brief   : Signal bundle between a raw-level source and input_debouncer.
// Revision: 1.0
// ============================================================================
interface input_debouncer_if #(
  parameter int GLITCH_W = 8
);
  logic                raw_i;
  logic                d_o;
  logic                rise_o;
  logic                fall_o;
  logic                busy_o;
  logic [GLITCH_W-1:0] glitch_cnt_o;

  // Source of the raw level; observer of the conditioned outputs.
  modport master (
    output raw_i,
    input  d_o, rise_o, fall_o, busy_o, glitch_cnt_o
  );

  modport slave (
    input  raw_i,
    output d_o, rise_o, fall_o, busy_o, glitch_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// Module  : input_debouncer
// Brief   : Synchronizer + debounce FSM with edge pulses and glitch counter.
// Revision: 1.0
// ============================================================================
module input_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit RESET_VALUE     = 1'b0,
  parameter int GLITCH_W        = 8
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input_debouncer_if.slave   dbif
);

  localparam int                CNT_W        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  C_CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  C_CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] C_GLITCH_MAX = '1;

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'd0,
    ST_PEND_HI   = 2'd1,
    ST_STABLE_HI = 2'd2,
    ST_PEND_LO   = 2'd3
  } state_t;

  localparam state_t C_RESET_STATE = RESET_VALUE ? ST_STABLE_HI : ST_STABLE_LO;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync_q;

  state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic                   r_d, w_d_nxt;
  logic                   r_rise, w_rise_nxt;
  logic                   r_fall, w_fall_nxt;
  logic                   r_busy, w_busy_nxt;
  logic [GLITCH_W-1:0]    r_glitch, w_glitch_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], dbif.raw_i};
    end
  end

  assign w_sync_q = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= C_RESET_STATE;
      r_cnt    <= '0;
      r_d      <= RESET_VALUE;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_busy   <= 1'b0;
      r_glitch <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_d      <= w_d_nxt;
      r_rise   <= w_rise_nxt;
      r_fall   <= w_fall_nxt;
      r_busy   <= w_busy_nxt;
      r_glitch <= w_glitch_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_d_nxt      = r_d;
    w_rise_nxt   = 1'b0;
    w_fall_nxt   = 1'b0;
    w_glitch_nxt = r_glitch;

    case (r_state)
      ST_STABLE_LO: begin
        if (w_sync_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_state_nxt = ST_STABLE_HI;
            w_d_nxt     = 1'b1;
            w_rise_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_PEND_HI;
            w_cnt_nxt   = C_CNT_ONE;
          end
        end
      end
      ST_PEND_HI: begin
        if (!w_sync_q) begin
          w_state_nxt = ST_STABLE_LO;
          w_cnt_nxt   = '0;
          if (r_glitch != C_GLITCH_MAX) w_glitch_nxt = r_glitch + 1'b1;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_nxt = ST_STABLE_HI;
          w_cnt_nxt   = '0;
          w_d_nxt     = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + C_CNT_ONE;
        end
      end
      ST_STABLE_HI: begin
        if (!w_sync_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_state_nxt = ST_STABLE_LO;
            w_d_nxt     = 1'b0;
            w_fall_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_PEND_LO;
            w_cnt_nxt   = C_CNT_ONE;
          end
        end
      end
      ST_PEND_LO: begin
        if (w_sync_q) begin
          w_state_nxt = ST_STABLE_HI;
          w_cnt_nxt   = '0;
          if (r_glitch != C_GLITCH_MAX) w_glitch_nxt = r_glitch + 1'b1;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_nxt = ST_STABLE_LO;
          w_cnt_nxt   = '0;
          w_d_nxt     = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + C_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = C_RESET_STATE;
        w_cnt_nxt   = '0;
      end
    endcase

    // busy tracks the state being entered so it stays aligned with r_state.
    w_busy_nxt = (w_state_nxt == ST_PEND_HI) || (w_state_nxt == ST_PEND_LO);
  end

  assign dbif.d_o          = r_d;
  assign dbif.rise_o       = r_rise;
  assign dbif.fall_o       = r_fall;
  assign dbif.busy_o       = r_busy;
  assign dbif.glitch_cnt_o = r_glitch;

endmodule
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module  : tb_input_debouncer
// Brief   : Directed scoreboard bench for input_debouncer (three instances).
// Revision: 1.0
// ============================================================================
module tb_input_debouncer;

  logic clk;
  logic reset;
  logic raw;

  typedef struct {
    int         sel;
    logic       d;
    logic       rise;
    logic       fall;
    logic       busy;
    logic [7:0] glitch;
  } exp_t;

  exp_t exp_q[$];
  int   tests;
  int   fails;

  // Instance 0: defaults. Instance 1: D=1, GLITCH_W=2. Instance 2: D=4, GLITCH_W=2.
  input_debouncer_if #(.GLITCH_W(8)) if0 ();
  input_debouncer_if #(.GLITCH_W(2)) if1 ();
  input_debouncer_if #(.GLITCH_W(2)) if2 ();

  assign if0.raw_i = raw;
  assign if1.raw_i = raw;
  assign if2.raw_i = raw;

  input_debouncer u_dut0 (.clk(clk), .reset(reset), .dbif(if0.slave));
  input_debouncer #(.DEBOUNCE_CYCLES(1), .GLITCH_W(2)) u_dut1 (
    .clk(clk), .reset(reset), .dbif(if1.slave));
  input_debouncer #(.DEBOUNCE_CYCLES(4), .GLITCH_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .dbif(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue what the selected instance must show
  // after the coming edge, then pop and compare once that edge has passed.
  task automatic step(input int sel, input logic rst_v, input logic raw_v,
                      input logic d, input logic rise, input logic fall,
                      input logic busy, input int glitch);
    exp_t e, got;
    logic [7:0] g_obs;
    logic d_obs, r_obs, f_obs, b_obs;
    reset = rst_v;
    raw   = raw_v;
    e.sel = sel; e.d = d; e.rise = rise; e.fall = fall; e.busy = busy;
    e.glitch = 8'(glitch);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    case (got.sel)
      1: begin
        d_obs = if1.d_o; r_obs = if1.rise_o; f_obs = if1.fall_o; b_obs = if1.busy_o;
        g_obs = {6'd0, if1.glitch_cnt_o};
      end
      2: begin
        d_obs = if2.d_o; r_obs = if2.rise_o; f_obs = if2.fall_o; b_obs = if2.busy_o;
        g_obs = {6'd0, if2.glitch_cnt_o};
      end
      default: begin
        d_obs = if0.d_o; r_obs = if0.rise_o; f_obs = if0.fall_o; b_obs = if0.busy_o;
        g_obs = if0.glitch_cnt_o;
      end
    endcase
    check($sformatf("d%0d.d_o", got.sel),    {7'd0, d_obs}, {7'd0, got.d});
    check($sformatf("d%0d.rise_o", got.sel), {7'd0, r_obs}, {7'd0, got.rise});
    check($sformatf("d%0d.fall_o", got.sel), {7'd0, f_obs}, {7'd0, got.fall});
    check($sformatf("d%0d.busy_o", got.sel), {7'd0, b_obs}, {7'd0, got.busy});
    check($sformatf("d%0d.glitch", got.sel), g_obs, got.glitch);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    raw   = 1'b0;

    // Reset state, and no pulse on the cycle reset is released.
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Clean rise: d_o changes after the 6th edge, busy on edges 3..5.
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0, 0);

    // Clean fall, mirror timing.
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Two-cycle high pulse is rejected and counted once.
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);

    // Bounce 1,0,1,0 then steady 1: two more glitches, one rise.
    step(0, 0, 1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 2);
    step(0, 0, 1, 0, 0, 0, 1, 2);
    step(0, 0, 1, 0, 0, 0, 0, 3);
    step(0, 0, 1, 0, 0, 0, 1, 3);
    step(0, 0, 1, 0, 0, 0, 1, 3);
    step(0, 0, 1, 0, 0, 0, 1, 3);
    step(0, 0, 1, 1, 1, 0, 0, 3);
    step(0, 0, 1, 1, 0, 0, 0, 3);

    // Reset while in PEND_HI with cnt=2, raw held high afterwards.
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0, 1, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 1, 0, 0, 0);

    // D=1: a single-cycle pulse passes straight through as rise then fall.
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    // GLITCH_W=2: five aborted PENDs saturate the counter at 3.
    step(2, 1, 0, 0, 0, 0, 0, 0);
    for (int g = 0; g < 5; g++) begin
      step(2, 0, 1, 0, 0, 0, 0, (g > 3) ? 3 : g);
      step(2, 0, 0, 0, 0, 0, 0, (g > 3) ? 3 : g);
      step(2, 0, 0, 0, 0, 0, 1, (g > 3) ? 3 : g);
    end
    step(2, 0, 0, 0, 0, 0, 0, 3);
    // The 8-bit instance saw the same five glitches without saturating.
    step(0, 0, 0, 0, 0, 0, 0, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
